// File: rtl/shift_register_universal.sv
// Universal shift register with parallel preset and a counted burst mode.
// Supported operations: hold, shift left/right, rotate left/right and
// arithmetic shift right. A burst performs N steps of one latched operation
// and reports progress on busy/done.
// Optional build macro: SHIFTREG_PARITY_EN adds a combinational parity output.
module shift_register_universal #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clockpulse,
    input  logic                   clear,
    input  logic [2:0]             mode,
    input  logic                   serialInLeft,
    input  logic                   serialInRight,
    input  logic                   enablePreset,
    input  logic [WIDTH-1:0]       preset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] shiftCount,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       notout,
    output logic                   serialOutLeft,
    output logic                   serialOutRight,
`ifdef SHIFTREG_PARITY_EN
    output logic                   parity,
`endif
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [WIDTH-1:0]       data, data_next;
    logic [2:0]             mode_lat, mode_lat_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;

    // One step of the selected operation; codes 000, 110 and 111 hold.
    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] value,
        input logic [2:0]       op,
        input logic             sil,
        input logic             sir
    );
        logic [WIDTH-1:0] result;
        result = value;
        case (op)
            3'b001:  result = {value[WIDTH-2:0], sil};
            3'b010:  result = {sir, value[WIDTH-1:1]};
            3'b011:  result = {value[WIDTH-2:0], value[WIDTH-1]};
            3'b100:  result = {value[0], value[WIDTH-1:1]};
            3'b101:  result = {value[WIDTH-1], value[WIDTH-1:1]};
            default: result = value;
        endcase
        return result;
    endfunction

    // Next-state logic: preset wins, then burst start, then the live step in IDLE;
    // in BURST the latched operation runs until the count is exhausted.
    always_comb begin
        state_next    = state;
        data_next     = data;
        mode_lat_next = mode_lat;
        count_next    = count;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (enablePreset) begin
                    data_next = preset;
                end else if (start && (shiftCount != '0)) begin
                    mode_lat_next = mode;
                    count_next    = shiftCount;
                    busy_next     = 1'b1;
                    state_next    = BURST;
                end else if (start) begin
                    done_next = 1'b1;
                end else begin
                    data_next = step(data, mode, serialInLeft, serialInRight);
                end
            end
            BURST: begin
                if (enablePreset) begin
                    data_next  = preset;
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    data_next  = step(data, mode_lat, serialInLeft, serialInRight);
                    count_next = count - 1'b1;
                    if (count == COUNT_WIDTH'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        busy_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with synchronous clear taking priority over everything.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state    <= IDLE;
            data     <= '0;
            mode_lat <= 3'b000;
            count    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            data     <= data_next;
            mode_lat <= mode_lat_next;
            count    <= count_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign out            = data;
    assign notout         = ~data;
    assign serialOutLeft  = data[WIDTH-1];
    assign serialOutRight = data[0];
    assign busy           = busy_reg;
    assign done           = done_reg;
`ifdef SHIFTREG_PARITY_EN
    assign parity         = ^data;
`endif

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (WIDTH=8, COUNT_WIDTH=4).
// Directed vector table, hand-written clear/parity sequences and a randomized
// run compared against a behavioural model of the register.
module tb_shift_register_universal;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clockpulse = 1'b0;
    logic          clear = 1'b1;
    logic [2:0]    mode = 3'b000;
    logic          serialInLeft = 1'b0;
    logic          serialInRight = 1'b0;
    logic          enablePreset = 1'b0;
    logic [W-1:0]  preset = '0;
    logic          start = 1'b0;
    logic [CW-1:0] shiftCount = '0;
    logic [W-1:0]  out;
    logic [W-1:0]  notout;
    logic          serialOutLeft;
    logic          serialOutRight;
    logic          busy;
    logic          done;
`ifdef SHIFTREG_PARITY_EN
    logic          parity;
`endif

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [W-1:0] m_out = '0;
    logic [2:0]   m_lmode = 3'b000;
    int           m_remaining = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;

    typedef struct {
        logic         en;
        logic [W-1:0] pre;
        logic [2:0]   md;
        logic         sil;
        logic         sir;
        logic         st;
        logic [CW-1:0] cnt;
        logic [W-1:0] exp_out;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t vectors[$];

    shift_register_universal #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clockpulse    (clockpulse),
        .clear         (clear),
        .mode          (mode),
        .serialInLeft  (serialInLeft),
        .serialInRight (serialInRight),
        .enablePreset  (enablePreset),
        .preset        (preset),
        .start         (start),
        .shiftCount    (shiftCount),
        .out           (out),
        .notout        (notout),
        .serialOutLeft (serialOutLeft),
        .serialOutRight(serialOutRight),
`ifdef SHIFTREG_PARITY_EN
        .parity        (parity),
`endif
        .busy          (busy),
        .done          (done)
    );

    always #5 clockpulse = ~clockpulse;

    // Arithmetic description of one operation on an unsigned W-bit value.
    function automatic logic [W-1:0] model_step(input logic [W-1:0] v, input logic [2:0] op,
                                                 input logic sil, input logic sir);
        int x, half, full, r;
        x    = int'(v);
        half = 1 << (W - 1);
        full = 1 << W;
        case (op)
            3'd1:    r = (x * 2 + int'(sil)) % full;
            3'd2:    r = x / 2 + int'(sir) * half;
            3'd3:    r = (x * 2) % full + x / half;
            3'd4:    r = x / 2 + (x % 2) * half;
            3'd5:    r = x / 2 + ((x >= half) ? half : 0);
            default: r = x;
        endcase
        return W'(r);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        if (clear) begin
            m_out = '0; m_lmode = 3'b000; m_remaining = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_remaining > 0) begin
            if (enablePreset) begin
                m_out = preset; m_remaining = 0; m_busy = 1'b0; m_done = 1'b0;
            end else begin
                m_out = model_step(m_out, m_lmode, serialInLeft, serialInRight);
                m_remaining = m_remaining - 1;
                m_busy = (m_remaining != 0);
                m_done = (m_remaining == 0);
            end
        end else begin
            m_busy = 1'b0;
            m_done = 1'b0;
            if (enablePreset) begin
                m_out = preset;
            end else if (start && shiftCount != 0) begin
                m_lmode = mode;
                m_remaining = int'(shiftCount);
                m_busy = 1'b1;
            end else if (start) begin
                m_done = 1'b1;
            end else begin
                m_out = model_step(m_out, mode, serialInLeft, serialInRight);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clockpulse);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] e_out,
                               input logic e_busy, input logic e_done);
        check({tag, ".out"}, out, e_out);
        check({tag, ".notout"}, notout, ~e_out);
        check({tag, ".sol"}, W'(serialOutLeft), W'(e_out[W-1]));
        check({tag, ".sor"}, W'(serialOutRight), W'(e_out[0]));
        check({tag, ".busy"}, W'(busy), W'(e_busy));
        check({tag, ".done"}, W'(done), W'(e_done));
`ifdef SHIFTREG_PARITY_EN
        check({tag, ".parity"}, W'(parity), W'(^e_out));
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        enablePreset  = v.en;
        preset        = v.pre;
        mode          = v.md;
        serialInLeft  = v.sil;
        serialInRight = v.sir;
        start         = v.st;
        shiftCount    = v.cnt;
        tick();
    endtask

    task automatic add_vec(input logic en, input logic [W-1:0] pre, input logic [2:0] md,
                           input logic sil, input logic sir, input logic st, input logic [CW-1:0] cnt,
                           input logic [W-1:0] eo, input logic eb, input logic ed);
        vec_t v;
        v.en = en; v.pre = pre; v.md = md; v.sil = sil; v.sir = sir; v.st = st; v.cnt = cnt;
        v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed;
        vectors.push_back(v);
    endtask

    initial begin
        // en  pre    md    sil   sir   st    cnt   out    busy  done
        // free-running shift left
        add_vec(1, 8'h03, 3'd0, 0, 0, 0, 4'd0, 8'h03, 0, 0);
        add_vec(0, 8'h00, 3'd1, 0, 0, 0, 4'd0, 8'h06, 0, 0);
        add_vec(0, 8'h00, 3'd1, 0, 0, 0, 4'd0, 8'h0C, 0, 0);
        add_vec(0, 8'h00, 3'd1, 0, 0, 0, 4'd0, 8'h18, 0, 0);
        add_vec(0, 8'h00, 3'd1, 1, 0, 0, 4'd0, 8'h31, 0, 0);
        // rotates and arithmetic shift right
        add_vec(1, 8'h81, 3'd0, 0, 0, 0, 4'd0, 8'h81, 0, 0);
        add_vec(0, 8'h00, 3'd3, 0, 0, 0, 4'd0, 8'h03, 0, 0);
        add_vec(0, 8'h00, 3'd3, 0, 0, 0, 4'd0, 8'h06, 0, 0);
        add_vec(0, 8'h00, 3'd4, 0, 0, 0, 4'd0, 8'h03, 0, 0);
        add_vec(0, 8'h00, 3'd4, 0, 0, 0, 4'd0, 8'h81, 0, 0);
        add_vec(0, 8'h00, 3'd4, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
        add_vec(1, 8'h80, 3'd0, 0, 0, 0, 4'd0, 8'h80, 0, 0);
        add_vec(0, 8'h00, 3'd5, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
        add_vec(0, 8'h00, 3'd5, 0, 0, 0, 4'd0, 8'hE0, 0, 0);
        add_vec(0, 8'h00, 3'd7, 1, 1, 0, 4'd0, 8'hE0, 0, 0);
        // burst of 3 shift-right steps, live mode toggled and ignored
        add_vec(1, 8'hA5, 3'd0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
        add_vec(0, 8'h00, 3'd2, 0, 1, 1, 4'd3, 8'hA5, 1, 0);
        add_vec(0, 8'h00, 3'd3, 0, 1, 0, 4'd0, 8'hD2, 1, 0);
        add_vec(0, 8'h00, 3'd0, 0, 1, 1, 4'd7, 8'hE9, 1, 0);
        add_vec(0, 8'h00, 3'd1, 0, 1, 0, 4'd0, 8'hF4, 0, 1);
        add_vec(0, 8'h00, 3'd0, 0, 0, 0, 4'd0, 8'hF4, 0, 0);
        // burst of 5 aborted by preset on the second step
        add_vec(0, 8'h00, 3'd1, 0, 0, 1, 4'd5, 8'hF4, 1, 0);
        add_vec(0, 8'h00, 3'd0, 0, 0, 0, 4'd0, 8'hE8, 1, 0);
        add_vec(1, 8'h3C, 3'd0, 0, 0, 0, 4'd0, 8'h3C, 0, 0);
        add_vec(0, 8'h00, 3'd0, 0, 0, 0, 4'd0, 8'h3C, 0, 0);
        // zero-length burst: done pulse only
        add_vec(0, 8'h00, 3'd1, 1, 0, 1, 4'd0, 8'h3C, 0, 1);
        add_vec(0, 8'h00, 3'd0, 0, 0, 0, 4'd0, 8'h3C, 0, 0);
        // back-to-back single-step bursts with start held high
        add_vec(0, 8'h00, 3'd3, 0, 0, 1, 4'd1, 8'h3C, 1, 0);
        add_vec(0, 8'h00, 3'd3, 0, 0, 1, 4'd1, 8'h78, 0, 1);
        add_vec(0, 8'h00, 3'd3, 0, 0, 1, 4'd1, 8'h78, 1, 0);
        add_vec(0, 8'h00, 3'd0, 0, 0, 0, 4'd0, 8'hF0, 0, 1);
        // burst with a latched hold code
        add_vec(0, 8'h00, 3'd6, 1, 1, 1, 4'd2, 8'hF0, 1, 0);
        add_vec(0, 8'h00, 3'd1, 1, 1, 0, 4'd0, 8'hF0, 1, 0);
        add_vec(0, 8'h00, 3'd1, 0, 0, 0, 4'd0, 8'hF0, 0, 1);

        // reset state
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("reset_hold", 8'h00, 1'b0, 1'b0);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i]);
            checkOutput($sformatf("vec%0d", i), vectors[i].exp_out, vectors[i].exp_busy, vectors[i].exp_done);
        end

        // clear in the middle of a burst, then confirm IDLE free-running
        enablePreset = 1'b1; preset = 8'h5A; start = 1'b0; mode = 3'd0;
        tick();
        enablePreset = 1'b0; start = 1'b1; shiftCount = 4'd5; mode = 3'd4;
        tick();
        start = 1'b0;
        tick();
        checkOutput("burst_pre_clear", 8'h2D, 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("mid_burst_clear", 8'h00, 1'b0, 1'b0);
        mode = 3'd1; serialInLeft = 1'b1;
        tick();
        checkOutput("idle_after_clear", 8'h01, 1'b0, 1'b0);

`ifdef SHIFTREG_PARITY_EN
        enablePreset = 1'b1; preset = 8'h07;
        tick();
        enablePreset = 1'b0; mode = 3'd0;
        check("parity_07", W'(parity), W'(1'b1));
`endif

        // randomized run against the behavioural model
        for (int n = 0; n < 400; n++) begin
            clear         = ($urandom_range(0, 99) == 0);
            enablePreset  = ($urandom_range(0, 15) == 0);
            preset        = W'($urandom);
            mode          = 3'($urandom_range(0, 7));
            serialInLeft  = 1'($urandom_range(0, 1));
            serialInRight = 1'($urandom_range(0, 1));
            start         = ($urandom_range(0, 7) == 0);
            shiftCount    = CW'($urandom_range(0, 6));
            tick();
            checkOutput($sformatf("rand%0d", n), m_out, m_busy, m_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
